mem_stall_ctrl: RTL and testbench

Sequencer for the data-memory access in the MEM stage of the pipelined MIPS core, for a data memory with a variable-latency request/ready handshake. When the instruction in MEM performs a load or store, the block issues the memory request and holds the F, D, E and M stages. It also drives the clear input of the M-to-W pipeline register so bubbles enter WB while MEM waits. When the access completes, it releases the pipeline for exactly one advance cycle.

---
 rtl/mem_stall_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory sequencer: issues the request, holds F/D/E/M, bubbles W until done.
// Optional watchdog: define MEM_TIMEOUT_EN to add the request timeout counter and ERR state.
module mem_stall_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ReadDataM,
   output logic        stallF,
   output logic        stallD,
   output logic        stallE,
   output logic        stallM,
   output logic        clearW,
   output logic        busy,
   output logic        timeout_err
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_stall_ctrl: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
`ifdef MEM_TIMEOUT_EN
      ,
      S_ERR  = 2'd3
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] read_data_q, read_data_d;
   logic        is_write_q, is_write_d;
   logic        access;
   logic        stall;

`ifdef MEM_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q, cnt_d;
   logic        timeout_err_q, timeout_err_d;
`endif

   assign access = MemReadM | MemWriteM;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      read_data_d = read_data_q;
      is_write_d  = is_write_q;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (access) begin
               stall       = 1'b1;
               mem_addr_d  = ALUOutM;
               mem_wdata_d = WriteDataM;
               // A simultaneous read+write is handled as a store.
               is_write_d  = MemWriteM;
               state_d     = S_REQ;
`ifdef MEM_TIMEOUT_EN
               cnt_d       = 16'd0;
`endif
            end
         end

         S_REQ: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            mem_we  = is_write_q;
            if (mem_ready) begin
               if (!is_write_q) begin
                  read_data_d = mem_rdata;
               end
               state_d = S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LAST) begin
               state_d       = S_ERR;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end

         // One release cycle; returning to IDLE keeps the same M instruction from re-triggering.
         S_DONE: begin
            state_d = S_IDLE;
         end

`ifdef MEM_TIMEOUT_EN
         S_ERR: begin
            stall = 1'b1;
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: the address/data registers are reset too, since their reset value of zero is observable on the ports.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         read_data_q <= 32'd0;
         is_write_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         read_data_q <= read_data_d;
         is_write_q  <= is_write_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= 16'd0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ReadDataM = read_data_q;
   assign busy      = (state_q != S_IDLE);

   // W is never stalled; it is cleared so bubbles enter WB while M is held.
   assign stallF = stall;
   assign stallD = stall;
   assign stallE = stall;
   assign stallM = stall;
   assign clearW = stall;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl; covers the timeout build when MEM_TIMEOUT_EN is defined.
module tb_mem_stall_ctrl;

   logic        clk;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] ReadDataM;
   logic        stallF, stallD, stallE, stallM, clearW;
   logic        busy, timeout_err;

   int checks   = 0;
   int failures = 0;

   mem_stall_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .ReadDataM  (ReadDataM),
      .stallF     (stallF),
      .stallD     (stallD),
      .stallE     (stallE),
      .stallM     (stallM),
      .clearW     (clearW),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven for the new cycle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stalls(input string tag, input logic expected);
      check({tag, "_stallF"}, 32'(stallF), 32'(expected));
      check({tag, "_stallM"}, 32'(stallM), 32'(expected));
      check({tag, "_clearW"}, 32'(clearW), 32'(expected));
   endtask

   initial begin
      reset      = 1'b1;
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      ALUOutM    = 32'd0;
      WriteDataM = 32'd0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'd0;
      #2;

      // Reset values
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_read_data", ReadDataM, 32'd0);
      check_stalls("rst_idle", 1'b0);
      MemReadM = 1'b1;
      #1;
      check_stalls("rst_follow_access", 1'b1);
      MemReadM = 1'b0;
      #1;
      check_stalls("rst_follow_noaccess", 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single load, ready in cycle 1
      ALUOutM  = 32'h40;
      MemReadM = 1'b1;
      #1;
      check_stalls("ld_c0", 1'b1);
      check("ld_c0_mem_req", 32'(mem_req), 32'd0);
      check("ld_c0_busy", 32'(busy), 32'd0);
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      check("ld_c1_mem_req", 32'(mem_req), 32'd1);
      check("ld_c1_mem_we", 32'(mem_we), 32'd0);
      check("ld_c1_mem_addr", mem_addr, 32'h40);
      check_stalls("ld_c1", 1'b1);
      next_cycle();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      #1;
      check("ld_c2_read_data", ReadDataM, 32'hDEADBEEF);
      check("ld_c2_mem_req", 32'(mem_req), 32'd0);
      check("ld_c2_busy", 32'(busy), 32'd1);
      check_stalls("ld_c2", 1'b0);
      next_cycle();
      MemReadM = 1'b0;
      #1;
      check("ld_c3_busy", 32'(busy), 32'd0);
      check("ld_c3_mem_addr_hold", mem_addr, 32'h40);

      // Store with ready in cycle 3
      ALUOutM    = 32'h80;
      WriteDataM = 32'h1234;
      MemWriteM  = 1'b1;
      #1;
      check_stalls("st_c0", 1'b1);
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         if (c == 3) mem_ready = 1'b1;
         #1;
         check($sformatf("st_c%0d_mem_req", c), 32'(mem_req), 32'd1);
         check($sformatf("st_c%0d_mem_we", c), 32'(mem_we), 32'd1);
         check($sformatf("st_c%0d_mem_wdata", c), mem_wdata, 32'h1234);
         check_stalls($sformatf("st_c%0d", c), 1'b1);
      end
      next_cycle();
      mem_ready = 1'b0;
      #1;
      check_stalls("st_c4", 1'b0);
      check("st_c4_mem_req", 32'(mem_req), 32'd0);
      check("st_c4_read_data", ReadDataM, 32'hDEADBEEF);
      next_cycle();
      MemWriteM = 1'b0;
      #1;
      check("st_c5_busy", 32'(busy), 32'd0);

      // Read+write together, then a back-to-back load
      ALUOutM    = 32'h100;
      WriteDataM = 32'hCAFE;
      MemReadM   = 1'b1;
      MemWriteM  = 1'b1;
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'h55555555;
      #1;
      check("rw_c1_mem_we", 32'(mem_we), 32'd1);
      check("rw_c1_mem_wdata", mem_wdata, 32'hCAFE);
      next_cycle();
      mem_ready = 1'b0;
      #1;
      check("rw_c2_read_data", ReadDataM, 32'hDEADBEEF);
      check_stalls("rw_c2", 1'b0);
      next_cycle();
      MemWriteM = 1'b0;
      ALUOutM   = 32'h200;
      #1;
      check("b2b_c3_no_dup_req", 32'(mem_req), 32'd0);
      check("b2b_c3_busy", 32'(busy), 32'd0);
      check_stalls("b2b_c3", 1'b1);
      next_cycle();
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADF00D;
      #1;
      check("b2b_c4_mem_req", 32'(mem_req), 32'd1);
      check("b2b_c4_mem_we", 32'(mem_we), 32'd0);
      check("b2b_c4_mem_addr", mem_addr, 32'h200);
      next_cycle();
      mem_ready = 1'b0;
      #1;
      check("b2b_c5_read_data", ReadDataM, 32'h0BADF00D);
      next_cycle();
      MemReadM  = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("idle_ready_busy", 32'(busy), 32'd0);
      next_cycle();
      #1;
      check("idle_ready_ignored_busy", 32'(busy), 32'd0);
      check("idle_ready_ignored_req", 32'(mem_req), 32'd0);
      mem_ready = 1'b0;

      // Asynchronous reset during the second REQ cycle
      ALUOutM  = 32'h300;
      MemReadM = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      check("rr_c2_mem_req", 32'(mem_req), 32'd1);
      reset    = 1'b1;
      MemReadM = 1'b0;
      #1;
      check("rr_async_mem_req", 32'(mem_req), 32'd0);
      check("rr_async_busy", 32'(busy), 32'd0);
      check_stalls("rr_async", 1'b0);
      next_cycle();
      reset = 1'b0;
      #1;
      check("rr_after_busy", 32'(busy), 32'd0);
      check("rr_after_mem_addr", mem_addr, 32'd0);
      check("rr_after_read_data", ReadDataM, 32'd0);
      check("rr_after_mem_we", 32'(mem_we), 32'd0);
      next_cycle();
      #1;
      check("rr_after_c1_mem_req", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
      // Watchdog trips after 4 REQ cycles without ready
      ALUOutM  = 32'h400;
      MemReadM = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         #1;
         check($sformatf("to_c%0d_mem_req", c), 32'(mem_req), 32'd1);
         check($sformatf("to_c%0d_timeout_err", c), 32'(timeout_err), 32'd0);
      end
      next_cycle();
      #1;
      check("to_err_mem_req", 32'(mem_req), 32'd0);
      check("to_err_timeout_err", 32'(timeout_err), 32'd1);
      check("to_err_busy", 32'(busy), 32'd1);
      check_stalls("to_err", 1'b1);
      MemReadM  = 1'b0;
      mem_ready = 1'b1;
      repeat (3) next_cycle();
      #1;
      check("to_err_sticky", 32'(timeout_err), 32'd1);
      check_stalls("to_err_held", 1'b1);
      mem_ready = 1'b0;
      reset     = 1'b1;
      #1;
      check("to_reset_clears", 32'(timeout_err), 32'd0);
      next_cycle();
      reset = 1'b0;

      // Ready on the final (4th) REQ cycle wins over the watchdog
      MemReadM = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         if (c == 4) begin
            mem_ready = 1'b1;
            mem_rdata = 32'h44;
         end
         #1;
         check($sformatf("tw_c%0d_mem_req", c), 32'(mem_req), 32'd1);
      end
      next_cycle();
      mem_ready = 1'b0;
      #1;
      check("tw_done_busy", 32'(busy), 32'd1);
      check("tw_done_timeout_err", 32'(timeout_err), 32'd0);
      check("tw_done_read_data", ReadDataM, 32'h44);
      check_stalls("tw_done", 1'b0);
      next_cycle();
      MemReadM = 1'b0;
      #1;
      check("tw_idle_busy", 32'(busy), 32'd0);
`else
      // Without the watchdog the block waits in REQ indefinitely
      ALUOutM  = 32'h400;
      MemReadM = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         next_cycle();
         #1;
         check($sformatf("wait_c%0d_mem_req", c), 32'(mem_req), 32'd1);
         check($sformatf("wait_c%0d_timeout_err", c), 32'(timeout_err), 32'd0);
      end
      mem_ready = 1'b1;
      mem_rdata = 32'h44;
      next_cycle();
      mem_ready = 1'b0;
      #1;
      check("wait_done_read_data", ReadDataM, 32'h44);
      check_stalls("wait_done", 1'b0);
      next_cycle();
      MemReadM = 1'b0;
      #1;
      check("wait_idle_busy", 32'(busy), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
